// File: rtl/polyphase_fir_scheduler.sv
// Sequencer for a time-multiplexed polyphase decimating FIR. It collects DECIM samples,
// then walks NTAPS taps through an external MAC and emits one saturated output sample.
module polyphase_fir_scheduler #(
    parameter int NTAPS = 16,
    parameter int DECIM = 4,
    parameter int DW    = 16,
    parameter int AW    = $clog2(NTAPS),
    parameter int ACC_W = 40,
    parameter int SHIFT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_data,
    output logic                    smp_we,
    output logic [AW-1:0]           smp_waddr,
    output logic [DW-1:0]           smp_wdata,
    output logic [AW-1:0]           smp_raddr,
    output logic [AW-1:0]           coef_raddr,
    output logic                    mac_clr,
    output logic                    mac_en,
    input  logic signed [ACC_W-1:0] acc_data,
    output logic signed [DW-1:0]    data_out,
    output logic                    valid_out
);

    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
    localparam logic [AW-1:0] K_LAST     = AW'(NTAPS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        wptr_q, wptr_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic [AW-1:0]        base_q, base_d;
    logic [AW-1:0]        k_q, k_d;
    logic                 drain_q, drain_d;
    logic                 mac_clr_q, mac_clr_d;
    logic                 mac_en_q, mac_en_d;
    logic signed [DW-1:0] data_out_q, data_out_d;

    logic signed [ACC_W-1:0] acc_shift;
    logic signed [DW-1:0]    sat_val;

    always_comb begin
        acc_shift = acc_data >>> SHIFT;
        if (acc_shift > SAT_MAX) begin
            sat_val = {1'b0, {(DW-1){1'b1}}};
        end else if (acc_shift < SAT_MIN) begin
            sat_val = {1'b1, {(DW-1){1'b0}}};
        end else begin
            sat_val = acc_shift[DW-1:0];
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        phase_d    = phase_q;
        base_d     = base_q;
        k_d        = k_q;
        drain_d    = drain_q;
        data_out_d = data_out_q;
        mac_clr_d  = 1'b0;
        mac_en_d   = 1'b0;
        in_ready   = 1'b0;
        smp_we     = 1'b0;
        smp_raddr  = '0;
        coef_raddr = '0;
        valid_out  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    smp_we = 1'b1;
                    wptr_d = wptr_q + AW'(1);
                    if (phase_q == PHASE_LAST) begin
                        phase_d = '0;
                        base_d  = wptr_q;
                        k_d     = '0;
                        state_d = S_RUN;
                    end else begin
                        phase_d = phase_q + PW'(1);
                    end
                end
            end
            S_RUN: begin
                // Delay line is walked newest-first; MAC strobes lag the issue by the RAM latency.
                smp_raddr  = base_q - k_q;
                coef_raddr = k_q;
                mac_clr_d  = (k_q == '0);
                mac_en_d   = (k_q != '0);
                k_d        = k_q + AW'(1);
                if (k_q == K_LAST) begin
                    drain_d = 1'b0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Second drain cycle sees the final accumulator; capture it so data_out lines up with valid_out.
                if (drain_q) begin
                    drain_d    = 1'b0;
                    data_out_d = sat_val;
                    state_d    = S_OUT;
                end else begin
                    drain_d = 1'b1;
                end
            end
            S_OUT: begin
                valid_out = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            phase_q    <= '0;
            base_q     <= '0;
            k_q        <= '0;
            drain_q    <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_en_q   <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            phase_q    <= phase_d;
            base_q     <= base_d;
            k_q        <= k_d;
            drain_q    <= drain_d;
            mac_clr_q  <= mac_clr_d;
            mac_en_q   <= mac_en_d;
            data_out_q <= data_out_d;
        end
    end

    assign smp_waddr = wptr_q;
    assign smp_wdata = in_data;
    assign mac_clr   = mac_clr_q;
    assign mac_en    = mac_en_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_polyphase_fir_scheduler.sv
// Self-checking bench for polyphase_fir_scheduler: models the sample RAM, coefficient ROM and MAC,
// and compares outputs against a direct convolution of the accepted input stream.
module tb_polyphase_fir_scheduler;

    localparam int NTAPS = 16;
    localparam int DECIM = 4;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int ACC_W = 40;
    localparam int SHIFT = 15;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic [DW-1:0]           in_data = '0;
    logic                    smp_we;
    logic [AW-1:0]           smp_waddr;
    logic [DW-1:0]           smp_wdata;
    logic [AW-1:0]           smp_raddr;
    logic [AW-1:0]           coef_raddr;
    logic                    mac_clr;
    logic                    mac_en;
    logic signed [ACC_W-1:0] acc_data;
    logic signed [DW-1:0]    data_out;
    logic                    valid_out;

    always #5 clk = ~clk;

    polyphase_fir_scheduler #(
        .NTAPS(NTAPS), .DECIM(DECIM), .DW(DW), .AW(AW), .ACC_W(ACC_W), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .smp_we(smp_we), .smp_waddr(smp_waddr), .smp_wdata(smp_wdata),
        .smp_raddr(smp_raddr), .coef_raddr(coef_raddr),
        .mac_clr(mac_clr), .mac_en(mac_en), .acc_data(acc_data),
        .data_out(data_out), .valid_out(valid_out)
    );

    // Shared MAC datapath model: 1-cycle RAM/ROM reads feeding a registered accumulator.
    logic signed [DW-1:0]    smp_ram  [NTAPS];
    logic signed [DW-1:0]    coef_rom [NTAPS];
    logic signed [DW-1:0]    rd_smp, rd_coef;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] acc_q;
    logic                    ram_clr = 1'b0;
    logic                    ovr_en  = 1'b0;
    logic signed [ACC_W-1:0] ovr_val = '0;

    assign prod     = rd_smp * rd_coef;
    assign acc_data = ovr_en ? ovr_val : acc_q;

    always @(posedge clk) begin
        rd_smp  <= smp_ram[smp_raddr];
        rd_coef <= coef_rom[coef_raddr];
        if (ram_clr) begin
            for (int i = 0; i < NTAPS; i++) smp_ram[i] <= '0;
        end else if (smp_we) begin
            smp_ram[smp_waddr] <= smp_wdata;
        end
        if (mac_clr)     acc_q <= ACC_W'(prod);
        else if (mac_en) acc_q <= acc_q + ACC_W'(prod);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        ovr_en   = 1'b0;
        ram_clr  = 1'b1;
        repeat (2) @(negedge clk);
        ram_clr = 1'b0;
        reset   = 1'b1;
    endtask

    // Feeds DECIM samples back-to-back from IDLE, then waits (bounded) for valid_out.
    task automatic feed_and_wait(output bit got);
        for (int i = 0; i < DECIM; i++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            if (valid_out) got = 1'b1;
            else @(negedge clk);
        end
    endtask

    // Reference: direct convolution over the accepted stream, unwritten history taken as zero.
    longint hist[$];
    longint exp_q[$];

    function automatic longint ref_out();
        longint s = 0;
        int n = hist.size();
        for (int k = 0; k < NTAPS; k++) begin
            if (n - 1 - k >= 0) s += longint'(coef_rom[k]) * hist[n-1-k];
        end
        s = s >>> SHIFT;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    typedef struct {
        logic signed [ACC_W-1:0] acc;
        longint                  exp;
    } sat_vec_t;

    sat_vec_t sv[8];

    initial begin
        bit got;
        int n, runs, k, outs, acc_n;
        bit prev_rdy;
        int vo_cnt;

        for (int i = 0; i < NTAPS; i++) coef_rom[i] = DW'($urandom_range(0, 8191)) - DW'(4096);

        sv[0] = '{40'sh0040000000,  32767};
        sv[1] = '{40'shFFC0000000, -32768};
        sv[2] = '{40'sh0000008000,      1};
        sv[3] = '{40'sh7FFFFFFFFF,  32767};
        sv[4] = '{40'sh8000000000, -32768};
        sv[5] = '{40'shFFFFFFFFFF,     -1};
        sv[6] = '{40'sh003FFF8000,  32767};
        sv[7] = '{40'shFFFFFF0000,     -2};

        // T1: reset state, during and after reset
        ram_clr = 1'b1;
        #2;
        check("t1_rst_ready", in_ready, 1);
        check("t1_rst_valid", valid_out, 0);
        check("t1_rst_data", data_out, 0);
        check("t1_rst_we", smp_we, 0);
        check("t1_rst_mac", {mac_clr, mac_en}, 0);
        repeat (2) @(negedge clk);
        ram_clr = 1'b0;
        reset   = 1'b1;
        #1;
        check("t1_ready", in_ready, 1);
        check("t1_valid", valid_out, 0);
        check("t1_data", data_out, 0);
        check("t1_we", smp_we, 0);
        @(negedge clk);

        // T2: decimation and tap walk timing
        for (int i = 0; i < DECIM; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i + 1);
            #1;
            check("t2_we", smp_we, 1);
            check("t2_waddr", smp_waddr, i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c <= NTAPS) begin
                check("t2_raddr", smp_raddr, ((3 - (c - 1)) + NTAPS) % NTAPS);
                check("t2_craddr", coef_raddr, c - 1);
            end
            check("t2_mac_clr", mac_clr, (c == 2));
            check("t2_mac_en", mac_en, (c >= 3 && c <= 17));
            check("t2_valid", valid_out, (c == 19));
            check("t2_ready", in_ready, (c >= 20));
            @(negedge clk);
        end

        // T4: saturation table, accumulator forced by the bench
        foreach (sv[i]) begin
            ovr_en  = 1'b1;
            ovr_val = sv[i].acc;
            feed_and_wait(got);
            check("t4_timeout", got, 1);
            check("t4_sat", data_out, sv[i].exp);
            @(negedge clk);
            check("t4_hold", data_out, sv[i].exp);
            check("t4_strobe", valid_out, 0);
        end
        ovr_en = 1'b0;

        // T3: backpressure while in_valid is held high
        do_reset();
        in_valid = 1'b1;
        for (int c = 0; c <= 23; c++) begin
            in_data = DW'(100 + c);
            #1;
            check("t3_we", smp_we, (c <= 3 || c == 23));
            check("t3_ready", in_ready, (c <= 3 || c == 23));
            check("t3_valid", valid_out, (c == 22));
            if (c == 23) check("t3_waddr", smp_waddr, 4);
            @(negedge clk);
        end
        in_valid = 1'b0;

        // T5: write pointer wrap and read base across five runs
        do_reset();
        n = 0; runs = 0; k = -1; prev_rdy = 1'b1;
        for (int c = 0; c < 300 && !(runs == 5 && k >= NTAPS); c++) begin
            in_valid = (n < 20);
            in_data  = DW'($urandom);
            #1;
            if (smp_we) begin
                check("t5_waddr", smp_waddr, n % NTAPS);
                n++;
            end
            if (!in_ready && prev_rdy) begin
                runs++;
                k = 0;
            end
            if (k >= 0 && k < NTAPS && !in_ready) begin
                if (runs == 5 || k == 0)
                    check("t5_raddr", smp_raddr, ((4 * runs - 1) - k + 64) % NTAPS);
                k++;
            end
            prev_rdy = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("t5_runs", runs, 5);
        check("t5_samples", n, 20);

        // T6: reset in the middle of a run
        do_reset();
        for (int i = 0; i < DECIM; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_pre_en", mac_en, 1);
        reset = 1'b0;
        #1;
        check("t6_en", mac_en, 0);
        check("t6_clr", mac_clr, 0);
        check("t6_rst_ready", in_ready, 1);
        check("t6_raddr", smp_raddr, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        vo_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (valid_out) vo_cnt++;
            @(negedge clk);
        end
        check("t6_no_valid", vo_cnt, 0);
        check("t6_ready", in_ready, 1);
        in_valid = 1'b1;
        #1;
        check("t6_we", smp_we, 1);
        check("t6_waddr", smp_waddr, 0);
        @(negedge clk);
        repeat (DECIM - 1) @(negedge clk);
        in_valid = 1'b0;
        check("t6_phase", in_ready, 0);

        // Random stream against the convolution reference
        do_reset();
        hist.delete();
        exp_q.delete();
        outs = 0; acc_n = 0;
        for (int c = 0; c < 3000 && outs < 12; c++) begin
            in_valid = (acc_n < 48) && ($urandom_range(0, 3) != 0);
            in_data  = DW'($urandom);
            #1;
            if (valid_out) begin
                if (exp_q.size() > 0) check("rnd_data", data_out, exp_q.pop_front());
                else check("rnd_spurious", 1, 0);
                outs++;
            end
            if (in_valid && in_ready) begin
                hist.push_back(longint'($signed(in_data)));
                acc_n++;
                if (acc_n % DECIM == 0) exp_q.push_back(ref_out());
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("rnd_outs", outs, 12);
        check("rnd_inputs", acc_n, 48);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
